data_sync_tx_arbiter: RTL and testbench

Source-domain scheduler that shares one data-synchronizer crossing between several requesters. It arbitrates round-robin among up to NUM_REQ requesters and captures the winner's word. It then drives the synchronizer's data bus and enable level for a fixed hold window, followed by a fixed quiet gap, so the destination detects exactly one enable edge per word. The block sits in the source clock domain, directly in front of the multi-flop data synchronizer.

---
 rtl/data_sync_tx_arbiter_if.sv | 23 ++
 rtl/data_sync_tx_arbiter.sv | 152 +++++++++++++++
 tb/tb_data_sync_tx_arbiter.sv | 245 ++++++++++++++++++++++++
 3 files changed

// File: rtl/data_sync_tx_arbiter_if.sv
// Handshake and synchronizer-facing bus bundle for data_sync_tx_arbiter.
// The requesters are the master side. The arbiter is the slave side.
interface data_sync_tx_arbiter_if #(
    parameter int NUM_REQ    = 4,
    parameter int DATA_WIDTH = 8
);
    logic [NUM_REQ-1:0]            req;
    logic [NUM_REQ*DATA_WIDTH-1:0] req_data;
    logic [NUM_REQ-1:0]            gnt;
    logic                          busy;
    logic [DATA_WIDTH-1:0]         unsync_bus;
    logic                          bus_enable;

    modport master (
        output req, req_data,
        input  gnt, busy, unsync_bus, bus_enable
    );

    modport slave (
        input  req, req_data,
        output gnt, busy, unsync_bus, bus_enable
    );
endinterface

// File: rtl/data_sync_tx_arbiter.sv
// Round-robin scheduler that feeds one shared data-synchronizer crossing: HOLD window with enable high, then a quiet GAP.
// Optional feature macro DATA_SYNC_ARB_XFER_CNT_EN adds a 16-bit completed-transfer counter output xfer_count.
module data_sync_tx_arbiter #(
    parameter int NUM_REQ     = 4,
    parameter int DATA_WIDTH  = 8,
    parameter int HOLD_CYCLES = 6,
    parameter int GAP_CYCLES  = 6
) (
    input  logic                 clk,
    input  logic                 rst,
`ifdef DATA_SYNC_ARB_XFER_CNT_EN
    output logic [15:0]          xfer_count,
`endif
    data_sync_tx_arbiter_if.slave arb
);
    localparam int PTR_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int PW1     = PTR_W + 1;
    localparam int CNT_MAX = (HOLD_CYCLES > GAP_CYCLES) ? HOLD_CYCLES : GAP_CYCLES;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_HOLD = 2'd1,
        ST_GAP  = 2'd2
    } state_t;

    state_t                 state_r, state_nx;
    logic [PTR_W-1:0]       ptr_r, ptr_nx;
    logic [CNT_W-1:0]       cnt_r, cnt_nx;
    logic [NUM_REQ-1:0]     gnt_r, gnt_nx;
    logic [DATA_WIDTH-1:0]  data_r, data_nx;
    logic                   en_r, en_nx;
    logic                   busy_r;
    logic [DATA_WIDTH-1:0]  word_s [NUM_REQ];
    logic [PW1-1:0]         idx_s;
    logic [PTR_W-1:0]       sel_s;
    logic                   found_s;
`ifdef DATA_SYNC_ARB_XFER_CNT_EN
    logic [15:0]            xfer_cnt_r, xfer_nx;
`endif

    for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
        assign word_s[g] = arb.req_data[g*DATA_WIDTH +: DATA_WIDTH];
    end

    // Round-robin pick: first active request at or above the pointer, wrapping modulo NUM_REQ.
    always_comb begin
        found_s = 1'b0;
        sel_s   = '0;
        idx_s   = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            idx_s = {1'b0, ptr_r} + PW1'(i);
            if (idx_s >= PW1'(NUM_REQ)) begin
                idx_s = idx_s - PW1'(NUM_REQ);
            end else begin
                idx_s = idx_s;
            end
            if (!found_s && arb.req[idx_s[PTR_W-1:0]]) begin
                found_s = 1'b1;
                sel_s   = idx_s[PTR_W-1:0];
            end else begin
                found_s = found_s;
            end
        end
    end

    // Next-state and next-output logic of the IDLE/HOLD/GAP sequencer.
    always_comb begin
        state_nx = state_r;
        ptr_nx   = ptr_r;
        cnt_nx   = cnt_r;
        gnt_nx   = '0;
        data_nx  = data_r;
        en_nx    = en_r;
`ifdef DATA_SYNC_ARB_XFER_CNT_EN
        xfer_nx  = xfer_cnt_r;
`endif
        case (state_r)
            ST_IDLE: begin
                if (found_s) begin
                    data_nx  = word_s[sel_s];
                    en_nx    = 1'b1;
                    gnt_nx   = NUM_REQ'(1) << sel_s;
                    ptr_nx   = (sel_s == PTR_W'(NUM_REQ - 1)) ? '0 : sel_s + PTR_W'(1);
                    cnt_nx   = CNT_W'(HOLD_CYCLES - 1);
                    state_nx = ST_HOLD;
                end else begin
                    state_nx = ST_IDLE;
                end
            end
            ST_HOLD: begin
                if (cnt_r == '0) begin
                    en_nx    = 1'b0;
                    cnt_nx   = CNT_W'(GAP_CYCLES - 1);
                    state_nx = ST_GAP;
`ifdef DATA_SYNC_ARB_XFER_CNT_EN
                    xfer_nx  = xfer_cnt_r + 16'd1;
`endif
                end else begin
                    cnt_nx   = cnt_r - CNT_W'(1);
                end
            end
            ST_GAP: begin
                if (cnt_r == '0) begin
                    state_nx = ST_IDLE;
                end else begin
                    cnt_nx   = cnt_r - CNT_W'(1);
                end
            end
            default: begin
                state_nx = ST_IDLE;
                en_nx    = 1'b0;
                cnt_nx   = '0;
            end
        endcase
    end

    // State and output registers; a reset on any edge abandons the in-flight word.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r    <= ST_IDLE;
            ptr_r      <= '0;
            cnt_r      <= '0;
            gnt_r      <= '0;
            data_r     <= '0;
            en_r       <= 1'b0;
            busy_r     <= 1'b0;
`ifdef DATA_SYNC_ARB_XFER_CNT_EN
            xfer_cnt_r <= 16'd0;
`endif
        end else begin
            state_r    <= state_nx;
            ptr_r      <= ptr_nx;
            cnt_r      <= cnt_nx;
            gnt_r      <= gnt_nx;
            data_r     <= data_nx;
            en_r       <= en_nx;
            busy_r     <= (state_nx != ST_IDLE);
`ifdef DATA_SYNC_ARB_XFER_CNT_EN
            xfer_cnt_r <= xfer_nx;
`endif
        end
    end

    assign arb.gnt        = gnt_r;
    assign arb.busy       = busy_r;
    assign arb.unsync_bus = data_r;
    assign arb.bus_enable = en_r;
`ifdef DATA_SYNC_ARB_XFER_CNT_EN
    assign xfer_count     = xfer_cnt_r;
`endif
endmodule

// File: tb/tb_data_sync_tx_arbiter.sv
// Self-checking bench for data_sync_tx_arbiter: a transfer-level model compared every cycle, plus directed literal checks.
module tb_data_sync_tx_arbiter;
    localparam int NR = 4;
    localparam int DW = 8;
    localparam int H  = 6;
    localparam int G  = 6;

    logic clk;
    logic rst;
`ifdef DATA_SYNC_ARB_XFER_CNT_EN
    logic [15:0] xfer_count;
`endif

    data_sync_tx_arbiter_if #(.NUM_REQ(NR), .DATA_WIDTH(DW)) arb ();

    data_sync_tx_arbiter #(
        .NUM_REQ(NR), .DATA_WIDTH(DW), .HOLD_CYCLES(H), .GAP_CYCLES(G)
    ) dut (
        .clk(clk),
        .rst(rst),
`ifdef DATA_SYNC_ARB_XFER_CNT_EN
        .xfer_count(xfer_count),
`endif
        .arb(arb)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: a transfer occupies H+G cycles after its grant; enable is high during the first H of them.
    int          m_left = 0;
    int          m_ptr = 0;
    logic [NR-1:0] m_gnt = '0;
    logic [DW-1:0] m_bus = '0;
    logic [15:0] m_xfer = 16'd0;
    bit          started = 1'b0;

    always @(posedge clk) begin
        if (rst) begin
            m_left = 0; m_ptr = 0; m_gnt = '0; m_bus = '0; m_xfer = 16'd0; started = 1'b1;
        end else begin
            m_gnt = '0;
            if (m_left > 0) begin
                if (m_left == G + 1) m_xfer = m_xfer + 16'd1;
                m_left = m_left - 1;
            end else if (arb.req != '0) begin
                int found;
                found = 0;
                for (int k = 0; k < NR; k++) begin
                    int idx;
                    idx = (m_ptr + k) % NR;
                    if (found == 0 && arb.req[idx]) begin
                        found  = 1;
                        m_gnt  = NR'(1) << idx;
                        m_bus  = arb.req_data[idx*DW +: DW];
                        m_ptr  = (idx + 1) % NR;
                        m_left = H + G;
                    end
                end
            end
        end
    end

    // Per-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        if (started) begin
            check("gnt", 32'(arb.gnt), 32'(m_gnt));
            check("busy", 32'(arb.busy), 32'(m_left > 0));
            check("bus_enable", 32'(arb.bus_enable), 32'(m_left > G));
            check("unsync_bus", 32'(arb.unsync_bus), 32'(m_bus));
`ifdef DATA_SYNC_ARB_XFER_CNT_EN
            check("xfer_count", 32'(xfer_count), 32'(m_xfer));
`endif
        end
    end

    task automatic do_reset();
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic wait_gnt();
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (arb.gnt != '0) break;
        end
        check("gnt_seen", 32'(arb.gnt != '0), 32'd1);
    endtask

    task automatic wait_idle();
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (arb.busy == 1'b0) break;
        end
        check("idle_reached", 32'(arb.busy), 32'd0);
    endtask

    initial begin
        int ne, nb, n, gi;
        int gidx [5];
        int gcyc [5];
        logic [DW-1:0] gbus [5];
        int exp_order [5];
        exp_order = '{0, 1, 2, 3, 0};

        rst = 1'b1;
        arb.req = '0;
        arb.req_data = '0;
        repeat (2) @(negedge clk);
        check("rst_gnt", 32'(arb.gnt), 32'd0);
        check("rst_busy", 32'(arb.busy), 32'd0);
        check("rst_bus", 32'(arb.unsync_bus), 32'd0);
        check("rst_en", 32'(arb.bus_enable), 32'd0);
        rst = 1'b0;
        @(negedge clk);

        // Single request from requester 1.
        arb.req_data = {8'h44, 8'h33, 8'hA5, 8'h11};
        arb.req = 4'b0010;
        @(negedge clk);
        check("t1_gnt", 32'(arb.gnt), 32'h2);
        check("t1_bus", 32'(arb.unsync_bus), 32'hA5);
        check("t1_en", 32'(arb.bus_enable), 32'd1);
        arb.req = 4'b0000;
        ne = 1; nb = 1;
        repeat (12) begin
            @(negedge clk);
            ne += int'(arb.bus_enable);
            nb += int'(arb.busy);
        end
        check("t1_en_cycles", 32'(ne), 32'd6);
        check("t1_busy_cycles", 32'(nb), 32'd12);
        check("t1_idle", 32'(arb.busy), 32'd0);

        // All four requesting continuously.
        do_reset();
        arb.req_data = {8'h44, 8'h33, 8'h22, 8'h11};
        arb.req = 4'b1111;
        n = 0;
        for (int c = 0; c < 100 && n < 5; c++) begin
            @(negedge clk);
            if (arb.gnt != '0) begin
                gi = 0;
                for (int b = 0; b < NR; b++) if (arb.gnt[b]) gi = b;
                gidx[n] = gi; gcyc[n] = c; gbus[n] = arb.unsync_bus;
                n++;
            end
        end
        arb.req = 4'b0000;
        check("t2_grant_count", 32'(n), 32'd5);
        for (int k = 0; k < 5; k++) begin
            if (k < n) begin
                check("t2_order", 32'(gidx[k]), 32'(exp_order[k]));
                check("t2_word", 32'(gbus[k]), 32'(8'h11 * (exp_order[k] + 1)));
                if (k > 0) check("t2_spacing", 32'(gcyc[k] - gcyc[k-1]), 32'd13);
            end
        end
        wait_idle();

        // Word captured at grant is frozen while the requester changes its data.
        do_reset();
        arb.req_data = {8'h44, 8'h33, 8'h22, 8'h5A};
        arb.req = 4'b0001;
        wait_gnt();
        arb.req = 4'b0000;
        arb.req_data[7:0] = 8'h3C;
        repeat (12) begin
            @(negedge clk);
            check("t3_frozen", 32'(arb.unsync_bus), 32'h5A);
        end

        // Pointer wrap after requester 3.
        do_reset();
        arb.req = 4'b1000;
        wait_gnt();
        check("t4_gnt3", 32'(arb.gnt), 32'h8);
        arb.req = 4'b0000;
        wait_idle();
        arb.req = 4'b1001;
        wait_gnt();
        check("t4_wrap", 32'(arb.gnt), 32'h1);
        arb.req = 4'b0000;
        wait_idle();

        // Reset in the third HOLD cycle.
        do_reset();
        arb.req = 4'b1111;
        wait_gnt();
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("t5_en", 32'(arb.bus_enable), 32'd0);
        check("t5_bus", 32'(arb.unsync_bus), 32'd0);
        check("t5_busy", 32'(arb.busy), 32'd0);
        rst = 1'b0;
        @(negedge clk);
        check("t5_regrant", 32'(arb.gnt), 32'h1);
        arb.req = 4'b0000;
        wait_idle();

`ifdef DATA_SYNC_ARB_XFER_CNT_EN
        do_reset();
        arb.req = 4'b0001;
        repeat (3) wait_gnt();
        arb.req = 4'b0000;
        wait_idle();
        check("cnt_three", 32'(xfer_count), 32'd3);
        arb.req = 4'b0001;
        wait_gnt();
        arb.req = 4'b0000;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("cnt_reset", 32'(xfer_count), 32'd0);
        force dut.xfer_cnt_r = 16'hFFFF;
        m_xfer = 16'hFFFF;
        @(posedge clk);
        #1;
        release dut.xfer_cnt_r;
        @(negedge clk);
        check("cnt_preset", 32'(xfer_count), 32'hFFFF);
        arb.req = 4'b0001;
        wait_gnt();
        arb.req = 4'b0000;
        wait_idle();
        check("cnt_wrap", 32'(xfer_count), 32'h0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
